// File: rtl/riscv_ex_muldiv.sv
// EX-stage iterative unsigned multiply/divide unit.
// Stalls ID/EX while iterating and pulses done with the result word.
module riscv_ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_idx_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_idx_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rdo_q, rdo_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              accept;
    logic              div0;
    logic              last;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step;

    // Multiply: acc = {partial high, multiplier}, shifted right each step.
    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        accept   = start && !flush && (state_q != CALC);
        div0     = op[1] && (rs2_val == '0);
        last     = (cnt_q == CNT_W'(XLEN - 1));
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        if (op_q[1]) begin
            if (div_diff[XLEN]) begin
                step = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        rdo_d   = rdo_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d  = op;
                    opb_d = op[1] ? rs2_val : rs1_val;
                    acc_d = {{XLEN{1'b0}}, (op[1] ? rs1_val : rs2_val)};
                    rd_d  = rd_idx_in;
                    cnt_d = '0;
                    if (div0) begin
                        state_d = DONE;
                        res_d   = op[0] ? rs1_val : '1;
                        rdo_d   = rd_idx_in;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    res_d   = op_q[0] ? step[2*XLEN-1:XLEN]
                                      : step[XLEN-1:0];
                    rdo_d   = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
            rdo_d   = rdo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
            rdo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            rdo_q   <= rdo_d;
            res_q   <= res_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign stall_req  = (start && state_q == IDLE) || (state_q == CALC);
    assign result     = res_q;
    assign rd_idx_out = rdo_q;

endmodule

// File: tb/tb_riscv_ex_muldiv.sv
// Scoreboard bench for riscv_ex_muldiv.
// Expected words come from a behavioural model using SV operators.
module tb_riscv_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_idx_in;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_idx_out;

    riscv_ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_idx_in (rd_idx_in),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result),
        .rd_idx_out(rd_idx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input bit push);
        exp_t e;
        op        = o;
        rs1_val   = a;
        rs2_val   = b;
        rd_idx_in = rd;
        start     = 1'b1;
        if (push) begin
            e.res = model(o, a, b);
            e.rd  = rd;
            e.due = cyc + ((o[1] && b == 0) ? 1 : 33);
            sb.push_back(e);
            last_res = e.res;
            last_rd  = rd;
        end
    endtask

    task automatic wait_done(output int sc, input int lim);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        #1;
        sc = stall_req ? 1 : 0;
        while (!got && n < lim) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n++;
            got = done;
            if (!got && stall_req) sc++;
        end
        chk("done_seen", got, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("rd_idx_out", rd_idx_out, e.rd);
                chk("latency", cyc, e.due);
            end
        end
    end

    logic [1:0]  t_op[8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [31:0] t_a[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, 100,
                             5, 5, 123, 123};
    logic [31:0] t_b[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 7,
                             9, 9, 0, 0};

    initial begin
        int sc;
        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        op        = '0;
        rs1_val   = '0;
        rs2_val   = '0;
        rd_idx_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd_idx_out, 0);
        chk("rst_stall", stall_req, 0);
        rst = 1'b0;

        @(negedge clk);
        issue(2'd0, 7, 6, 5'd5, 1);
        wait_done(sc, 100);
        chk("mul_stall_cycles", sc, 33);
        chk("stall_in_done", stall_req, 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue(t_op[i], t_a[i], t_b[i], 5'(i + 10), 1);
            wait_done(sc, 100);
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                            : $urandom;
            @(negedge clk);
            issue(2'($urandom_range(0, 3)), $urandom, b,
                  5'($urandom_range(1, 31)), 1);
            wait_done(sc, 100);
        end

        @(negedge clk);
        issue(2'd2, 1000, 3, 5'd9, 0);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("start_flush_busy", busy, 0);

        @(negedge clk);
        issue(2'd2, 1000, 3, 5'd9, 0);
        repeat (11) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_before_flush", busy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_result", result, last_res);
        chk("flush_rd", rd_idx_out, last_rd);
        repeat (40) @(negedge clk);

        @(negedge clk);
        issue(2'd0, 3, 4, 5'd7, 0);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_rd", rd_idx_out, 0);
        chk("arst_stall", stall_req, 0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        issue(2'd1, 32'h8000_0001, 32'h0000_0003, 5'd21, 1);
        wait_done(sc, 100);
        issue(2'd3, 77, 5, 5'd12, 1);
        wait_done(sc, 100);
        chk("b2b_stall_cycles", sc, 32);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
